// File: rtl/adc_frame_align_ctrl.sv
// FCO-based frame alignment controller: trains the deserializer with bitslips until the
// 0xFC/0x0F/0xC0 frame-clock pattern is stable, then monitors lock and retrains on loss.
module adc_frame_align_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned LOCK_COUNT    = 48,
    parameter int unsigned ERR_LIMIT     = 4
) (
    input  logic       data_in_clk,
    input  logic       rstn,
    input  logic       enable,
    input  logic [7:0] fco_word,
    output logic       bitslip,
    output logic       gearbox_valid,
    output logic       gearbox_rstn,
    output logic       locked,
    output logic       align_error,
    output logic [3:0] slip_count,
    output logic [7:0] relock_count
);

    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
    localparam logic [3:0] ERR_LAST  = 4'(ERR_LIMIT - 1);
    localparam logic [3:0] MAX_SLIPS = 4'd7;
    localparam logic [7:0] FCO_W0 = 8'hFC;
    localparam logic [7:0] FCO_W1 = 8'h0F;
    localparam logic [7:0] FCO_W2 = 8'hC0;

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_CHECK, S_SLIP, S_LOCKED, S_FAIL
    } state_t;

    state_t           state;
    logic [SET_W-1:0] settle_cnt;
    logic [7:0]       match_cnt;
    logic [3:0]       err_cnt;
    logic [1:0]       phase;

    logic [1:0] phase_succ;
    logic       succ_is_fc;
    logic       word_ok;
    logic       first_hit;
    logic [1:0] first_phase;

    function automatic logic [7:0] ref_word(input logic [1:0] p);
        case (p)
            2'd0:    return FCO_W0;
            2'd1:    return FCO_W1;
            default: return FCO_W2;
        endcase
    endfunction

    // Pattern compare against the expected phase, plus first-word phase acquisition
    always_comb begin
        phase_succ  = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        succ_is_fc  = (ref_word(phase_succ) == FCO_W0);
        word_ok     = (fco_word == ref_word(phase));
        first_hit   = 1'b1;
        first_phase = 2'd0;
        case (fco_word)
            FCO_W0:  first_phase = 2'd1;
            FCO_W1:  first_phase = 2'd2;
            FCO_W2:  first_phase = 2'd0;
            default: first_hit   = 1'b0;
        endcase
    end

    always_ff @(posedge data_in_clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            settle_cnt    <= '0;
            match_cnt     <= '0;
            err_cnt       <= '0;
            phase         <= '0;
            bitslip       <= 1'b0;
            gearbox_valid <= 1'b0;
            gearbox_rstn  <= 1'b0;
            locked        <= 1'b0;
            align_error   <= 1'b0;
            slip_count    <= '0;
            relock_count  <= '0;
        end else if (!enable) begin
            state         <= S_IDLE;
            settle_cnt    <= '0;
            match_cnt     <= '0;
            err_cnt       <= '0;
            phase         <= '0;
            bitslip       <= 1'b0;
            gearbox_valid <= 1'b0;
            gearbox_rstn  <= 1'b0;
            locked        <= 1'b0;
            align_error   <= 1'b0;
            slip_count    <= '0;
        end else begin
            bitslip <= 1'b0;
            case (state)
                S_IDLE: begin
                    state      <= S_SETTLE;
                    settle_cnt <= SETTLE_LOAD;
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state     <= S_CHECK;
                        match_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                S_CHECK: begin
                    if ((match_cnt == '0) ? first_hit : word_ok) begin
                        match_cnt <= match_cnt + 8'd1;
                        phase     <= (match_cnt == '0) ? first_phase : phase_succ;
                        if (match_cnt == LOCK_LAST) begin
                            state         <= S_LOCKED;
                            locked        <= 1'b1;
                            gearbox_rstn  <= 1'b1;
                            err_cnt       <= '0;
                            gearbox_valid <= succ_is_fc;
                        end
                    end else if (slip_count == MAX_SLIPS) begin
                        state       <= S_FAIL;
                        align_error <= 1'b1;
                    end else begin
                        state      <= S_SLIP;
                        bitslip    <= 1'b1;
                        slip_count <= slip_count + 4'd1;
                    end
                end
                S_SLIP: begin
                    state      <= S_SETTLE;
                    settle_cnt <= SETTLE_LOAD;
                end
                S_LOCKED: begin
                    phase <= phase_succ;
                    if (word_ok) begin
                        err_cnt <= '0;
                    end else if (err_cnt == ERR_LAST) begin
                        // Lost lock: hold the gearbox in reset and restart training
                        state         <= S_SETTLE;
                        settle_cnt    <= SETTLE_LOAD;
                        err_cnt       <= '0;
                        locked        <= 1'b0;
                        gearbox_valid <= 1'b0;
                        gearbox_rstn  <= 1'b0;
                        slip_count    <= '0;
                        if (relock_count != 8'hFF) relock_count <= relock_count + 8'd1;
                    end else begin
                        err_cnt <= err_cnt + 4'd1;
                    end
                    if ((word_ok || err_cnt != ERR_LAST) && succ_is_fc) gearbox_valid <= 1'b1;
                end
                S_FAIL: begin
                    state <= S_FAIL;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_align_ctrl.sv
// Bench for adc_frame_align_ctrl: serial FCO stream model with bitslip rotation,
// behavioural reference checked every cycle, plus directed literal checks.
module tb_adc_frame_align_ctrl;

    localparam int SETTLE = 16;
    localparam int LOCKN  = 48;
    localparam int ERRL   = 4;

    logic       data_in_clk = 1'b0;
    logic       rstn;
    logic       enable;
    logic [7:0] fco_word;
    logic       bitslip, gearbox_valid, gearbox_rstn, locked, align_error;
    logic [3:0] slip_count;
    logic [7:0] relock_count;

    adc_frame_align_ctrl #(.SETTLE_CYCLES(SETTLE), .LOCK_COUNT(LOCKN), .ERR_LIMIT(ERRL)) dut (
        .data_in_clk  (data_in_clk),
        .rstn         (rstn),
        .enable       (enable),
        .fco_word     (fco_word),
        .bitslip      (bitslip),
        .gearbox_valid(gearbox_valid),
        .gearbox_rstn (gearbox_rstn),
        .locked       (locked),
        .align_error  (align_error),
        .slip_count   (slip_count),
        .relock_count (relock_count)
    );

    always #5 data_in_clk = ~data_in_clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Stream generator state: serial pattern of 6 ones / 6 zeros, read 8 bits per word
    int n          = 0;
    int off        = 0;
    bit corrupt    = 0;
    bit const_zero = 0;
    int slips_seen = 0;
    int last_slip  = -1;
    bit prev_valid = 0;

    // Reference model (modes: 0 idle, 1 settle, 2 check, 3 slip, 4 locked, 5 fail)
    int m_mode, m_settle, m_run, m_phase, m_errs, m_slips, m_relock;
    bit m_valid;

    function automatic logic [7:0] refw(int p);
        case (p)
            0:       return 8'hFC;
            1:       return 8'h0F;
            default: return 8'hC0;
        endcase
    endfunction

    function automatic logic [7:0] gen(int idx, int o);
        logic [7:0] w;
        for (int b = 0; b < 8; b++) w[7-b] = (((idx * 8 + o + b) % 12) < 6);
        return w;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_settle = 0; m_run = 0; m_phase = 0; m_errs = 0;
        m_slips = 0; m_relock = 0; m_valid = 0;
    endtask

    task automatic model_step(input bit en, input logic [7:0] w);
        bit ok;
        int idx;
        if (!en) begin
            m_mode = 0; m_slips = 0; m_valid = 0;
            return;
        end
        case (m_mode)
            0: begin m_mode = 1; m_settle = SETTLE; end
            1: begin
                m_settle--;
                if (m_settle == 0) begin m_mode = 2; m_run = 0; end
            end
            2: begin
                if (m_run == 0) begin
                    idx = -1;
                    for (int i = 0; i < 3; i++) if (w == refw(i)) idx = i;
                    ok = (idx >= 0);
                    if (ok) begin m_run = 1; m_phase = (idx + 1) % 3; end
                end else begin
                    ok = (w == refw(m_phase));
                    if (ok) begin m_run++; m_phase = (m_phase + 1) % 3; end
                end
                if (!ok) begin
                    if (m_slips < 7) begin m_mode = 3; m_slips++; end
                    else m_mode = 5;
                end else if (m_run == LOCKN) begin
                    m_mode = 4; m_errs = 0; m_valid = (refw(m_phase) == 8'hFC);
                end
            end
            3: begin m_mode = 1; m_settle = SETTLE; end
            4: begin
                ok = (w == refw(m_phase));
                m_phase = (m_phase + 1) % 3;
                m_errs = ok ? 0 : m_errs + 1;
                if (m_errs == ERRL) begin
                    m_mode = 1; m_settle = SETTLE; m_valid = 0; m_slips = 0; m_errs = 0;
                    if (m_relock < 255) m_relock++;
                end else if (refw(m_phase) == 8'hFC) begin
                    m_valid = 1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        logic [16:0] act, exp;
        act = {bitslip, gearbox_valid, gearbox_rstn, locked, align_error, slip_count, relock_count};
        exp = {m_mode == 3, m_valid, m_mode == 4, m_mode == 4, m_mode == 5, 4'(m_slips), 8'(m_relock)};
        chk("outputs", int'(act), int'(exp));
    endtask

    task automatic drive_word();
        fco_word = const_zero ? 8'h00 : (corrupt ? 8'h55 : gen(n, off));
        n++;
    endtask

    task automatic step();
        @(posedge data_in_clk);
        if (!rstn) model_reset();
        else model_step(enable, fco_word);
        @(negedge data_in_clk);
        cyc++;
        compare_all();
        if (bitslip) begin
            if (last_slip >= 0) chk("slip_spacing", int'(cyc - last_slip >= SETTLE + 1), 1);
            last_slip = cyc;
            off = (off + 11) % 12;
            slips_seen++;
        end
        drive_word();
        if (gearbox_valid && !prev_valid && !corrupt && !const_zero)
            chk("valid_on_fc", int'(fco_word), 8'hFC);
        prev_valid = gearbox_valid;
    endtask

    task automatic wait_lock(input int budget);
        int i = 0;
        while (!locked && i < budget) begin step(); i++; end
        chk("lock_reached", int'(locked), 1);
    endtask

    int cnt;

    initial begin
        rstn = 1'b0; enable = 1'b0; drive_word();
        model_reset();
        #12;
        chk("reset_outputs",
            int'({bitslip, gearbox_valid, gearbox_rstn, locked, align_error, slip_count, relock_count}), 0);
        @(negedge data_in_clk);
        rstn = 1'b1;
        repeat (3) step();

        // Aligned stream: lock latency and gearbox_valid on a frame boundary
        off = 0; slips_seen = 0; enable = 1'b1; cnt = 0;
        while (!locked && cnt < 200) begin step(); cnt++; end
        chk("aligned_lock_latency", cnt, SETTLE + LOCKN + 1);
        chk("aligned_no_slips", slips_seen, 0);
        chk("aligned_slip_count", int'(slip_count), 0);
        repeat (6) step();
        chk("aligned_valid_high", int'(gearbox_valid), 1);

        // Three-bit offset: one rotation per bitslip until aligned
        enable = 1'b0; step();
        off = 3; slips_seen = 0; enable = 1'b1;
        wait_lock(400);
        chk("offset_slips", slips_seen, 3);
        chk("offset_slip_count", int'(slip_count), 3);

        // Error tolerance in LOCKED, then retrain
        repeat (5) step();
        corrupt = 1; repeat (3) step(); corrupt = 0; repeat (2) step();
        chk("hold_lock_3err", int'(locked), 1);
        corrupt = 1; repeat (4) step(); corrupt = 0; repeat (2) step();
        chk("retrain_unlocked", int'(locked), 0);
        chk("retrain_valid", int'(gearbox_valid), 0);
        chk("retrain_relock_cnt", int'(relock_count), 1);
        chk("retrain_slip_cleared", int'(slip_count), 0);
        wait_lock(200);

        // Enable drop mid-CHECK
        enable = 1'b0; step(); enable = 1'b1;
        repeat (30) step();
        enable = 1'b0; step();
        chk("disable_outputs",
            int'({bitslip, gearbox_valid, gearbox_rstn, locked, align_error, slip_count}), 0);
        chk("disable_keeps_relock", int'(relock_count), 1);

        // Asynchronous reset mid-LOCKED
        enable = 1'b1;
        wait_lock(200);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        chk("async_rst_outputs",
            int'({bitslip, gearbox_valid, gearbox_rstn, locked, align_error, slip_count, relock_count}), 0);
        step();
        rstn = 1'b1;
        wait_lock(200);

        // Dead FCO: exhaust the bitslip budget then sit in FAIL
        enable = 1'b0; step();
        const_zero = 1; slips_seen = 0; enable = 1'b1; cnt = 0;
        while (!align_error && cnt < 400) begin step(); cnt++; end
        chk("fail_reached", int'(align_error), 1);
        chk("fail_slips", slips_seen, 7);
        chk("fail_slip_count", int'(slip_count), 7);
        repeat (10) step();
        chk("fail_locked", int'(locked), 0);
        chk("fail_valid", int'(gearbox_valid), 0);
        enable = 1'b0; step();
        chk("fail_cleared", int'(align_error), 0);
        const_zero = 0;

        // Randomized offsets, corruption bursts and enable drops
        for (int t = 0; t < 6; t++) begin
            enable = 1'b0; step();
            off = $urandom_range(0, 11); enable = 1'b1;
            wait_lock(400);
            for (int b = 0; b < 5; b++) begin
                repeat ($urandom_range(5, 30)) step();
                corrupt = 1; repeat ($urandom_range(1, 5)) step(); corrupt = 0;
                if ($urandom_range(0, 7) == 0) begin enable = 1'b0; step(); enable = 1'b1; end
                repeat (2) step();
                wait_lock(400);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
